cache_merge_fifo: RTL and testbench



---
 rtl/cache_merge_fifo.sv | 118 +++++++++++
 tb/tb_cache_merge_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cache_merge_fifo.sv
// cache_merge_fifo: first-word-fall-through request buffer behind the
// two-input mutex merge. Each accepted drive is answered with a one-cycle
// o_free pulse once the word is in storage. A one-entry holding register
// soaks up a drive that lands while storage is full, so no drive is lost.
module cache_merge_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_drive,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_free,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Storage array; no reset, since o_data is masked while empty.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_reg,   rptr_reg;
  logic [CW-1:0]    count_reg,  count_next;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_valid_reg;
  logic             free_reg;
  logic             err_reg;

  logic             pop;
  logic             space;
  logic             write_hold;
  logic             write_drive;
  logic             write_en;
  logic             capture;
  logic             violation;
  logic [WIDTH-1:0] write_data;

  // Outputs depend on registered state only; i_ready reaches them only via the next edge.
  assign o_valid = (count_reg != '0);
  assign o_data  = o_valid ? mem[rptr_reg] : '0;
  assign o_count = count_reg;
  assign o_free  = free_reg;
  assign o_err   = err_reg;

  // Write arbitration: a held word always goes ahead of a fresh drive.
  always_comb begin
    pop         = o_valid & i_ready;
    space       = (count_reg < DEPTH_C) | pop;
    write_hold  = hold_valid_reg & space;
    write_drive = i_drive & space & ~hold_valid_reg;
    write_en    = write_hold | write_drive;
    capture     = i_drive & ~space & ~hold_valid_reg;
    violation   = i_drive & hold_valid_reg;
    write_data  = hold_valid_reg ? hold_reg : i_data;
    count_next  = count_reg + (write_en ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
  end

  // Storage write port; writing at wptr while full-and-popping is safe because
  // the popped head was consumed from the same slot before this edge.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wptr_reg] <= write_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally, full/empty come from count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (write_en) wptr_reg <= wptr_reg + AW'(1);
      if (pop)      rptr_reg <= rptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Overflow holding register: fills on a drive with no room, drains as soon as room appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
    end else begin
      if (capture) begin
        hold_reg       <= i_data;
        hold_valid_reg <= 1'b1;
      end else if (write_hold) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end

  // Free pulse follows every committed write; reset cancels any pending pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_reg <= 1'b0;
    end else begin
      free_reg <= write_en;
    end
  end

  // Sticky protocol-violation flag: drive arrived while the hold was occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (violation) begin
      err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_merge_fifo.sv
// Testbench for cache_merge_fifo: directed scenarios followed by random
// drive/ready traffic, all checked against a queue-based reference model.
module tb_cache_merge_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 35;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_drive = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_ready = 1'b0;
  logic             o_free;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [CW-1:0]    o_count;
  logic             o_err;

  cache_merge_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_drive (i_drive),
    .i_data  (i_data),
    .o_free  (o_free),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_hold;
  bit               m_hold_v;
  bit               m_err;
  bit               m_free;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    check_eq({tag, ".valid"}, 64'(o_valid), 64'(mq.size() != 0));
    check_eq({tag, ".data"},  64'(o_data),  64'(head));
    check_eq({tag, ".count"}, 64'(o_count), 64'(mq.size()));
    check_eq({tag, ".free"},  64'(o_free),  64'(m_free));
    check_eq({tag, ".err"},   64'(o_err),   64'(m_err));
  endtask

  // One clock: apply inputs (we are just after a negedge), advance the model,
  // let the edge happen, then compare on the following negedge.
  task automatic cycle(input string tag, input bit drv, input logic [WIDTH-1:0] d, input bit rdy);
    bit pop;
    bit room;
    i_drive = drv;
    i_data  = d;
    i_ready = rdy;
    pop  = (mq.size() != 0) && rdy;
    room = (mq.size() < DEPTH) || pop;
    m_free = 1'b0;
    if (pop) begin
      $display("pop  data=%09h", mq[0]);
      void'(mq.pop_front());
    end
    if (m_hold_v && room) begin
      mq.push_back(m_hold);
      m_hold_v = 1'b0;
      m_free   = 1'b1;
      if (drv) m_err = 1'b1;
    end else if (drv) begin
      if (m_hold_v) begin
        m_err = 1'b1;
      end else if (room) begin
        mq.push_back(d);
        m_free = 1'b1;
      end else begin
        m_hold   = d;
        m_hold_v = 1'b1;
      end
    end
    if (drv) $display("drive data=%09h ready=%0b", d, rdy);
    @(posedge clk);
    @(negedge clk);
    i_drive = 1'b0;
    check_all(tag);
  endtask

  // Reset asserted asynchronously in the middle of a low clock phase.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    m_hold_v = 1'b0;
    m_err    = 1'b0;
    m_free   = 1'b0;
    check_all({tag, ".async"});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_hold   = '0;
    m_hold_v = 1'b0;
    m_err    = 1'b0;
    m_free   = 1'b0;
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic flow: drive then pop; count 0 -> 1 -> 0
    cycle("basic.drive", 1'b1, 35'h1_2345_6789, 1'b1);
    check_eq("basic.data_lit", 64'(o_data), 64'h1_2345_6789);
    cycle("basic.pop", 1'b0, '0, 1'b1);
    check_eq("basic.count_zero", 64'(o_count), 64'd0);

    // Fill in order, then drain
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 35'(i), 1'b0);
    check_eq("fill.count_full", 64'(o_count), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("fill.order", 64'(o_data), 64'(i));
      cycle("drain", 1'b0, '0, 1'b1);
    end

    // Overflow into the holding register
    for (int i = 0; i < DEPTH; i++) cycle("ovf.fill", 1'b1, 35'(100 + i), 1'b0);
    cycle("ovf.hold", 1'b1, 35'h7_FFFF_FFFF, 1'b0);
    check_eq("ovf.no_free", 64'(o_free), 64'd0);
    cycle("ovf.wait", 1'b0, '0, 1'b0);
    cycle("ovf.release", 1'b0, '0, 1'b1);
    check_eq("ovf.free", 64'(o_free), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check_eq("ovf.last", 64'(o_data), 64'h7_FFFF_FFFF);
      cycle("ovf.drain", 1'b0, '0, 1'b1);
    end

    // Full FIFO with simultaneous pop and drive: direct write
    for (int i = 0; i < DEPTH; i++) cycle("fp.fill", 1'b1, 35'(200 + i), 1'b0);
    cycle("fp.both", 1'b1, 35'h5_5555_5555, 1'b1);
    check_eq("fp.count", 64'(o_count), 64'(DEPTH));
    check_eq("fp.free", 64'(o_free), 64'd1);
    for (int i = 0; i < DEPTH; i++) cycle("fp.drain", 1'b0, '0, 1'b1);

    // Protocol violation: second drive while hold occupied
    for (int i = 0; i < DEPTH; i++) cycle("pv.fill", 1'b1, 35'(300 + i), 1'b0);
    cycle("pv.hold", 1'b1, 35'h2_AAAA_AAAA, 1'b0);
    cycle("pv.bad", 1'b1, 35'h3_BAD0_BAD0, 1'b0);
    check_eq("pv.err", 64'(o_err), 64'd1);
    for (int i = 0; i < DEPTH + 3; i++) begin
      check_eq("pv.not_bad", 64'(o_data == 35'h3_BAD0_BAD0), 64'd0);
      cycle("pv.drain", 1'b0, '0, 1'b1);
    end
    check_eq("pv.err_sticky", 64'(o_err), 64'd1);
    do_reset("pv.rst");
    check_eq("pv.err_cleared", 64'(o_err), 64'd0);

    // Reset mid-stream with an o_free pending
    for (int i = 0; i < 5; i++) cycle("rs.fill", 1'b1, 35'(400 + i), 1'b0);
    check_eq("rs.free_pending", 64'(o_free), 64'd1);
    do_reset("rs");
    cycle("rs.after", 1'b0, '0, 1'b0);
    cycle("rs.after2", 1'b0, '0, 1'b1);

    // Random traffic; violations are kept rare so most of the run has o_err low
    for (int n = 0; n < 400; n++) begin
      bit drv;
      logic [WIDTH-1:0] d;
      d   = {3'($urandom), 32'($urandom)};
      drv = ($urandom_range(0, 2) == 0) && (!m_hold_v || $urandom_range(0, 19) == 0);
      cycle("rand", drv, d, 1'($urandom_range(0, 1)));
      if (n == 200) do_reset("rand.rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
